nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencer that performs a multi-nibble (default 16-bit) addition by time-multiplexing one external combinational 4-bit full-adder slice. It drives the slice's operand and carry-in inputs one nibble per cycle, LSB first, and captures the slice's sum and carry-out. It assembles the wide result and reports it with a busy/done handshake. It sits directly around the adder slice, acting as both its feeder and its consumer.

## Interface

Parameters:
- NIB, default 4: number of nibbles per operand; operand width W = 4*NIB; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op_a  in  W  operand A; sampled on the accepted start.
- op_b  in  W  operand B; sampled on the accepted start.
- cin  in  1  carry into nibble 0; sampled on the accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  W  registered result; holds until the next accepted start.
- cout  out  1  registered carry out of the top nibble.
- ovf  out  1  registered two's-complement overflow.
- add_a  out  4  to adder slice, A nibble.
- add_b  out  4  to adder slice, B nibble.
- add_cin  out  1  to adder slice, carry-in.
- add_s  in  4  from adder slice, sum nibble (bits 3:0 of its sum output).
- add_cout  in  1  from adder slice, carry-out.

## Operation

- FSM states:
  - IDLE: waits for start. start=1 moves to RUN and loads a_reg, b_reg and carry_reg from op_a, op_b and cin. It sets idx to 0, clears sum_reg, clears cout and clears ovf.
  - RUN: drives the adder slice as follows.
    - add_a = a_reg[4*idx+3 : 4*idx], add_b = b_reg[4*idx+3 : 4*idx], add_cin = carry_reg.
    - Each edge: sum_reg[4*idx+3 : 4*idx] <= add_s, carry_reg <= add_cout, idx <= idx+1.
    - When idx = NIB-1, it goes to DONE.
  - DONE: done=1 for exactly one cycle. cout = carry_reg. ovf = (a_reg[W-1] == b_reg[W-1]) && (sum_reg[W-1] != a_reg[W-1]). The next state is always IDLE.
- Adder slice drive outside RUN: add_a, add_b and add_cin are driven to 0.
- The block performs no arithmetic of its own on sum bits. All sum and carry bits come from the slice, and the carry chain ripples through carry_reg between nibbles.
- idx width is ceil(log2(NIB)), minimum 1. idx never exceeds NIB-1.
- start in RUN or DONE is ignored and not queued. start must be re-presented in IDLE.
- op_a, op_b and cin may change freely after the accepted start.
- sum, cout and ovf are registered outputs. They are stable from the DONE cycle until the edge that accepts the next start, where they clear to 0.

## Timing

- Reset (rst_n=0 at an edge) sets:
  - state = IDLE, busy = 0, done = 0
  - sum = 0, cout = 0, ovf = 0, idx = 0, carry_reg = 0
  - add_a / add_b / add_cin = 0
- Reset takes priority over every other event, including mid-RUN. A partial result is discarded and no done pulse is issued.
- Start accepted at edge T0:
  - busy=1 during cycles T0+1 .. T0+NIB.
  - Nibble k is presented to the slice in cycle T0+1+k.
  - done=1 in cycle T0+NIB+1.
  - Latency from start to done is NIB+1 cycles.
- Back-to-back throughput: a start asserted in the DONE cycle is ignored. The earliest new acceptance is the first IDLE cycle, so one operation completes every NIB+2 cycles.
- The adder slice path is combinational, from add_a/add_b/add_cin to add_s/add_cout. It must settle within one clk period.
- busy and done are never high in the same cycle.

## Test plan

- NIB=4, op_a=0x1234, op_b=0x4321, cin=0 -> add_a sequence 4,3,2,1. done 5 cycles after start. sum=0x5555, cout=0, ovf=0.
- 0xFFFF + 0x0001, cin=0 -> carry ripples through all 4 nibbles (add_cin sequence 0,1,1,1). sum=0x0000, cout=1, ovf=0.
- 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1. Also 0x8000 + 0x8000 -> sum=0x0000, cout=1, ovf=1.
- 0x0000 + 0xFFFF, cin=1 -> sum=0x0000, cout=1.
- start held high continuously -> operations accepted every 6 cycles. Operand changes during RUN do not affect the result. start in the DONE cycle is not accepted.
- rst_n=0 for one cycle during nibble 2 of 0xAAAA+0x5555 -> next cycle state IDLE, busy=0, sum=0, no done pulse. A new start then completes normally with sum=0xFFFF.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder sequencer: feeds one external 4-bit full-adder slice one nibble per cycle,
// LSB first, rippling the carry through carry_q and assembling the registered result.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; slice inputs held at 0
// S_RUN  | nibble idx_q presented to the slice, its sum captured each edge
// S_DONE | one-cycle done pulse; sum/cout/ovf valid
module nibble_serial_adder_ctrl #(
    parameter int NIB = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4*NIB-1:0]   op_a,
    input  logic [4*NIB-1:0]   op_b,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [4*NIB-1:0]   sum,
    output logic               cout,
    output logic               ovf,
    output logic [3:0]         add_a,
    output logic [3:0]         add_b,
    output logic               add_cin,
    input  logic [3:0]         add_s,
    input  logic               add_cout
);

    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_RUN: begin
                add_cin = carry_q;
                for (int k = 0; k < NIB; k++) begin
                    if (idx_q == IW'(k)) begin
                        add_a           = a_q[4*k +: 4];
                        add_b           = b_q[4*k +: 4];
                        sum_d[4*k +: 4] = add_s;
                    end
                end
                carry_d = add_cout;
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                    // Result flags registered on the final nibble so they are valid in S_DONE.
                    cout_d  = add_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[3] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (NIB=4) with a behavioural 4-bit adder slice.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a, op_b;
    logic        cin;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;
    logic [3:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = add_a + add_b + add_cin;

    nibble_serial_adder_ctrl #(.NIB(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation; operands are scrambled right after acceptance to show they are not re-read.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] es, input logic ec, input logic eo);
        logic       carry;
        logic [4:0] t;
        @(negedge clk);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op_a = ~a; op_b = ~b; cin = ~c;
        check({tag, ":sum_cleared"}, sum, 0);
        check({tag, ":flags_cleared"}, {cout, ovf}, 0);
        carry = c;
        for (int k = 0; k < 4; k++) begin
            check({tag, ":busy"}, {busy, done}, 2'b10);
            check({tag, ":add_a"}, add_a, a[4*k +: 4]);
            check({tag, ":add_b"}, add_b, b[4*k +: 4]);
            check({tag, ":add_cin"}, add_cin, carry);
            t = a[4*k +: 4] + b[4*k +: 4] + carry;
            carry = t[4];
            @(negedge clk);
        end
        check({tag, ":done"}, {busy, done}, 2'b01);
        check({tag, ":sum"}, sum, es);
        check({tag, ":cout"}, cout, ec);
        check({tag, ":ovf"}, ovf, eo);
        check({tag, ":slice_idle"}, {add_a, add_b, add_cin}, 0);
        @(negedge clk);
        check({tag, ":done_pulse"}, {busy, done}, 2'b00);
        check({tag, ":sum_hold"}, {sum, cout, ovf}, {es, ec, eo});
    endtask

    initial begin
        int first, second, ndone;
        rst_n = 1'b0; start = 1'b0; op_a = 16'h0; op_b = 16'h0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bd", {busy, done}, 0);
        check("rst_res", {sum, cout, ovf}, 0);
        check("rst_slice", {add_a, add_b, add_cin}, 0);
        rst_n = 1'b1;

        run_op("basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("ovf_neg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("cin_in",   16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);

        // start held high: DONE-cycle start ignored, next acceptance in the following IDLE cycle
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        op_a = 16'h0101; op_b = 16'h0202;
        check("hold:busy0", busy, 1);
        first = -1; second = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (done) begin
                if (first < 0) begin
                    first = cyc;
                    check("hold:sum1", sum, 16'h3333);
                end else begin
                    second = cyc;
                    check("hold:sum2", sum, 16'h0303);
                end
            end
            if (first >= 0 && cyc == first + 1)
                check("hold:idle_after_done", {busy, done}, 2'b00);
            if (second >= 0) break;
            @(negedge clk);
        end
        check("hold:first_done", first, 5);
        check("hold:period", second - first, 6);
        start = 1'b0;
        repeat (8) @(negedge clk);

        // reset during nibble 2
        @(negedge clk);
        op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid:add_a_nib2", add_a, 4'hA);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid:bd", {busy, done}, 0);
        check("rst_mid:sum", {sum, cout, ovf}, 0);
        check("rst_mid:slice", {add_a, add_b, add_cin}, 0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("rst_mid:no_done", ndone, 0);
        run_op("after_rst", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
